// File: rtl/fa_checker_if.sv
// Bus bundle between a full-adder checker and its environment.
// The master side drives the sample/DUT pins; the slave side is the checker.
interface fa_checker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic             clr;
  logic             a;
  logic             b;
  logic             cin;
  logic             dut_sum;
  logic             dut_cout;
  logic             mismatch;
  logic [CNT_W-1:0] err_count;
  logic             alarm;
  logic [1:0]       state;
  logic             cap_valid;
  logic [2:0]       cap_vec;
  logic [15:0]      cap_stamp;

  modport master (
    output en, clr, a, b, cin, dut_sum, dut_cout,
    input  mismatch, err_count, alarm, state, cap_valid, cap_vec, cap_stamp
  );

  modport slave (
    input  en, clr, a, b, cin, dut_sum, dut_cout,
    output mismatch, err_count, alarm, state, cap_valid, cap_vec, cap_stamp
  );
endinterface

// File: rtl/fa_checker.sv
// Online checker for a registered full adder: delays each sample by LATENCY, compares
// against the DUT result, counts errors and raises a sticky alarm. FA_CHECKER_CAPTURE_EN adds first-failure capture.
module fa_checker #(
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned ALARM_THRESH = 4
) (
  input logic        clk,
  input logic        rst,
  fa_checker_if.slave bus
);
  localparam int unsigned WARM_W = 3;
  localparam int unsigned LAST   = LATENCY - 1;
  localparam int          LAT_I  = int'(LATENCY);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  THRESH    = CNT_W'(ALARM_THRESH);

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    MONITOR = 2'd1,
    ALARM   = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [WARM_W-1:0]         warm_q, warm_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                      mismatch_q, mismatch_d;
  logic                      alarm_q, alarm_d;
  logic [LATENCY-1:0]        pipe_en_q;
  logic [LATENCY-1:0][2:0]   pipe_vec_q;
  logic [2:0]                old_vec;
  logic                      exp_sum;
  logic                      exp_cout;
  logic                      fail;

  // Delay line aligning each sample with the DUT's registered result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_en_q  <= '0;
      pipe_vec_q <= '0;
    end else begin
      pipe_en_q[0]  <= bus.en;
      pipe_vec_q[0] <= {bus.a, bus.b, bus.cin};
      for (int i = 1; i < LAT_I; i++) begin
        pipe_en_q[i]  <= pipe_en_q[i-1];
        pipe_vec_q[i] <= pipe_vec_q[i-1];
      end
    end
  end

  assign old_vec  = pipe_vec_q[LAST];
  assign exp_sum  = old_vec[2] ^ old_vec[1] ^ old_vec[0];
  assign exp_cout = (old_vec[2] & old_vec[1]) | (old_vec[2] & old_vec[0]) |
                    (old_vec[1] & old_vec[0]);
  assign fail     = pipe_en_q[LAST] && (state_q != WARMUP) &&
                    ({bus.dut_sum, bus.dut_cout} != {exp_sum, exp_cout});
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= WARMUP;
      warm_q     <= '0;
      cnt_q      <= '0;
      mismatch_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_q     <= warm_d;
      cnt_q      <= cnt_d;
      mismatch_q <= mismatch_d;
      alarm_q    <= alarm_d;
    end
  end

  // Next state; clr beats a simultaneous failure for counting but not for the pulse
  always_comb begin
    state_d    = state_q;
    warm_d     = warm_q;
    cnt_d      = cnt_q;
    mismatch_d = fail;
    alarm_d    = 1'b0;

    if (bus.clr) begin
      cnt_d = '0;
    end else if (fail) begin
      cnt_d = cnt_inc;
    end

    unique case (state_q)
      WARMUP: begin
        if (warm_q == WARM_LAST) begin
          state_d = MONITOR;
        end else begin
          warm_d = warm_q + WARM_W'(1);
        end
      end
      MONITOR: begin
        if (fail && !bus.clr && (cnt_inc >= THRESH)) begin
          state_d = ALARM;
        end
      end
      ALARM: begin
        if (bus.clr) begin
          state_d = MONITOR;
        end
      end
      default: state_d = WARMUP;
    endcase

    alarm_d = (state_d == ALARM);
  end

  assign bus.mismatch  = mismatch_q;
  assign bus.err_count = cnt_q;
  assign bus.alarm     = alarm_q;
  assign bus.state     = state_q;

`ifdef FA_CHECKER_CAPTURE_EN
  logic [15:0] cyc_q;
  logic        cap_valid_q;
  logic [2:0]  cap_vec_q;
  logic [15:0] cap_stamp_q;

  // Cycle stamp of a failing sample is the counter value when it was taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q       <= '0;
      cap_valid_q <= 1'b0;
      cap_vec_q   <= '0;
      cap_stamp_q <= '0;
    end else begin
      cyc_q <= cyc_q + 16'd1;
      if (bus.clr) begin
        cap_valid_q <= 1'b0;
      end else if (fail && !cap_valid_q) begin
        cap_valid_q <= 1'b1;
        cap_vec_q   <= old_vec;
        cap_stamp_q <= cyc_q - 16'(LATENCY);
      end
    end
  end

  assign bus.cap_valid = cap_valid_q;
  assign bus.cap_vec   = cap_vec_q;
  assign bus.cap_stamp = cap_stamp_q;
`else
  assign bus.cap_valid = 1'b0;
  assign bus.cap_vec   = 3'b000;
  assign bus.cap_stamp = 16'h0000;
`endif

endmodule

// File: tb/tb_fa_checker.sv
// Self-checking bench for fa_checker: directed tables/sequences plus random traffic
// against a sample-queue reference model; a second narrow-counter instance covers saturation.
module tb_fa_checker;
  localparam int L    = 2;
  localparam int TH   = 4;
  localparam int MAXC = 255;
  localparam int SL   = 1;

  logic clk;
  logic rst;

  fa_checker_if #(.CNT_W(8)) m_if ();
  fa_checker_if #(.CNT_W(2)) s_if ();

  fa_checker #(.LATENCY(2), .CNT_W(8), .ALARM_THRESH(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if.slave)
  );

  fa_checker #(.LATENCY(1), .CNT_W(2), .ALARM_THRESH(3)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (s_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] vec;
    logic [1:0] out;
    int         idx;
  } smp_t;

  typedef struct {
    logic       en;
    logic [2:0] vec;
    logic [1:0] fault;
    logic       exp_mm;
    int         exp_cnt;
  } vec_t;

  smp_t mq[$];
  smp_t sq[$];
  int   n_chk;
  int   n_err;
  int   edge_n;
  int   m_cnt;
  int   m_st;
  logic m_mm;
  logic m_capv;
  logic [2:0] m_cvec;
  int   m_cstamp;

  // Full-adder truth from the number of set inputs
  function automatic logic [1:0] golden(input logic [2:0] v);
    int ones;
    ones = int'(v[2]) + int'(v[1]) + int'(v[0]);
    return {(ones % 2) == 1, ones >= 2};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic check_all();
    chk("mismatch", 32'(m_if.mismatch), 32'(m_mm));
    chk("err_count", 32'(m_if.err_count), 32'(m_cnt));
    chk("state", 32'(m_if.state), 32'(m_st));
    chk("alarm", 32'(m_if.alarm), 32'(m_st == 2));
`ifdef FA_CHECKER_CAPTURE_EN
    chk("cap_valid", 32'(m_if.cap_valid), 32'(m_capv));
    if (m_capv) begin
      chk("cap_vec", 32'(m_if.cap_vec), 32'(m_cvec));
      chk("cap_stamp", 32'(m_if.cap_stamp), 32'(m_cstamp));
    end
`else
    chk("cap_valid", 32'(m_if.cap_valid), 32'd0);
    chk("cap_vec", 32'(m_if.cap_vec), 32'd0);
    chk("cap_stamp", 32'(m_if.cap_stamp), 32'd0);
`endif
  endtask

  task automatic model_reset();
    mq.delete();
    sq.delete();
    edge_n   = 0;
    m_cnt    = 0;
    m_st     = 0;
    m_mm     = 1'b0;
    m_capv   = 1'b0;
    m_cvec   = 3'b000;
    m_cstamp = 0;
  endtask

  // Present one sample (and the DUT results due now), clock it, update model, compare
  task automatic step(input logic en, input logic [2:0] v, input logic clr,
                      input logic [1:0] flt, input logic [1:0] sflt);
    smp_t s;
    smp_t r;
    smp_t sr;
    logic [1:0] pres;
    logic [1:0] spres;
    logic fail;
    r    = '{en: 1'b0, vec: 3'b000, out: 2'b00, idx: 0};
    sr   = r;
    pres = 2'b00;
    spres = 2'b00;
    fail = 1'b0;
    s.en  = en;
    s.vec = v;
    s.idx = edge_n;
    s.out = golden(v) ^ flt;
    mq.push_back(s);
    if (mq.size() > L) begin
      r    = mq.pop_front();
      pres = r.out;
      fail = r.en && (r.out != golden(r.vec)) && (edge_n >= L);
    end
    s.out = golden(v) ^ sflt;
    sq.push_back(s);
    if (sq.size() > SL) begin
      sr    = sq.pop_front();
      spres = sr.out;
    end
    m_if.en = en; m_if.a = v[2]; m_if.b = v[1]; m_if.cin = v[0]; m_if.clr = clr;
    m_if.dut_sum = pres[1]; m_if.dut_cout = pres[0];
    s_if.en = en; s_if.a = v[2]; s_if.b = v[1]; s_if.cin = v[0]; s_if.clr = clr;
    s_if.dut_sum = spres[1]; s_if.dut_cout = spres[0];
    @(posedge clk);
    #1;
    edge_n++;
    m_mm = fail;
    if (clr) begin
      m_cnt  = 0;
      m_capv = 1'b0;
      if (m_st == 2) m_st = 1;
    end else if (fail) begin
      if (m_cnt < MAXC) m_cnt++;
      if (!m_capv) begin
        m_capv   = 1'b1;
        m_cvec   = r.vec;
        m_cstamp = r.idx % 65536;
      end
      if (m_st == 1 && m_cnt >= TH) m_st = 2;
    end
    if (m_st == 0 && edge_n >= L) m_st = 1;
    check_all();
  endtask

  // Fault one sample, then clock golden samples until its comparison has registered
  task automatic inject(input logic [2:0] v, input logic [1:0] flt);
    step(1'b1, v, 1'b0, flt, 2'b00);
    for (int i = 0; i < L; i++) step(1'b1, 3'b000, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("sat_rst_cnt", 32'(s_if.err_count), 32'd0);
    chk("sat_rst_state", 32'(s_if.state), 32'd0);
    chk("sat_rst_mm", 32'(s_if.mismatch), 32'd0);
    @(posedge clk);
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  vec_t tbl[16];
  int   mm_seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 16; i++) begin
      tbl[i].en      = 1'b1;
      tbl[i].vec     = (i == 10) ? 3'b110 : 3'(i % 8);
      tbl[i].fault   = (i == 10) ? 2'b10 : 2'b00;
      tbl[i].exp_mm  = (i == 10 + L);
      tbl[i].exp_cnt = (i >= 10 + L) ? 1 : 0;
    end
    rst = 1'b0;
    m_if.en = 1'b0; m_if.clr = 1'b0; m_if.a = 1'b1; m_if.b = 1'b0; m_if.cin = 1'b1;
    m_if.dut_sum = 1'b1; m_if.dut_cout = 1'b1;
    s_if.en = 1'b0; s_if.clr = 1'b0; s_if.a = 1'b0; s_if.b = 1'b0; s_if.cin = 1'b0;
    s_if.dut_sum = 1'b1; s_if.dut_cout = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Golden DUT: all vectors many times, never a mismatch
    mm_seen = 0;
    for (int i = 0; i < 800; i++) begin
      step(1'b1, 3'(i % 8), 1'b0, 2'b00, 2'b00);
      if (m_if.mismatch) mm_seen++;
    end
    chk("golden_mm_seen", 32'(mm_seen), 32'd0);
    chk("golden_err_count", 32'(m_if.err_count), 32'd0);
    chk("golden_state", 32'(m_if.state), 32'd1);

    // Single inverted sum on the 110 sample taken at cycle 10
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].en, tbl[i].vec, 1'b0, tbl[i].fault, 2'b00);
      chk("tbl_mismatch", 32'(m_if.mismatch), 32'(tbl[i].exp_mm));
      chk("tbl_err_count", 32'(m_if.err_count), 32'(tbl[i].exp_cnt));
    end
`ifdef FA_CHECKER_CAPTURE_EN
    chk("tbl_cap_valid", 32'(m_if.cap_valid), 32'd1);
    chk("tbl_cap_vec", 32'(m_if.cap_vec), 32'b110);
    chk("tbl_cap_stamp", 32'(m_if.cap_stamp), 32'd10);
`endif

    // Failures 2..4 raise the alarm; a fifth keeps the first capture
    inject(3'b001, 2'b01);
    chk("f2_cnt", 32'(m_if.err_count), 32'd2);
    inject(3'b001, 2'b01);
    chk("f3_cnt", 32'(m_if.err_count), 32'd3);
    chk("f3_alarm", 32'(m_if.alarm), 32'd0);
    inject(3'b001, 2'b01);
    chk("f4_mm", 32'(m_if.mismatch), 32'd1);
    chk("f4_alarm", 32'(m_if.alarm), 32'd1);
    chk("f4_state", 32'(m_if.state), 32'd2);
    inject(3'b011, 2'b10);
    chk("f5_cnt", 32'(m_if.err_count), 32'd5);
`ifdef FA_CHECKER_CAPTURE_EN
    chk("f5_cap_vec", 32'(m_if.cap_vec), 32'b110);
`endif
    step(1'b1, 3'b000, 1'b1, 2'b00, 2'b00);
    chk("clr_cnt", 32'(m_if.err_count), 32'd0);
    chk("clr_alarm", 32'(m_if.alarm), 32'd0);
    chk("clr_state", 32'(m_if.state), 32'd1);

    // clr coinciding with a failure: pulse yes, count/capture no
    inject(3'b101, 2'b10);
    chk("pre_clr_cnt", 32'(m_if.err_count), 32'd1);
    step(1'b1, 3'b111, 1'b0, 2'b10, 2'b00);
    for (int i = 0; i < L - 1; i++) step(1'b1, 3'b000, 1'b0, 2'b00, 2'b00);
    step(1'b1, 3'b000, 1'b1, 2'b00, 2'b00);
    chk("clrfail_mm", 32'(m_if.mismatch), 32'd1);
    chk("clrfail_cnt", 32'(m_if.err_count), 32'd0);
    chk("clrfail_cap_valid", 32'(m_if.cap_valid), 32'd0);

    // Narrow counter: cout stuck at 1 for 10 samples saturates at 3
    for (int j = 0; j < 12; j++) begin
      step(1'b1, 3'b000, 1'b0, 2'b00, (j < 10) ? 2'b01 : 2'b00);
      chk("sat_cnt", 32'(s_if.err_count), 32'((j < 3) ? j : 3));
    end
    chk("sat_alarm", 32'(s_if.alarm), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [1:0] flt;
      flt = ($urandom_range(7) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      step(1'($urandom_range(3) != 0), 3'($urandom_range(7)),
           1'($urandom_range(31) == 0), flt, 2'b00);
    end

    // Reset with failures still in the delay line
    step(1'b1, 3'b100, 1'b0, 2'b11, 2'b00);
    step(1'b1, 3'b010, 1'b0, 2'b11, 2'b00);
    do_reset();
    for (int i = 0; i < L; i++) begin
      step(1'b1, 3'b100, 1'b0, 2'b11, 2'b00);
      chk("post_rst_mm", 32'(m_if.mismatch), 32'd0);
    end
    step(1'b1, 3'b000, 1'b0, 2'b00, 2'b00);
    chk("post_rst_first_cmp", 32'(m_if.mismatch), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 3'(i), 1'b0, 2'b00, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fa_checker.md
FA_CHECKER -- requirements
Module: fa_checker

Interface
REQ-001 The block SHALL have these parameters:
- LATENCY, 2: DUT input-to-output latency in clock cycles; legal range 1..4.
- CNT_W, 8: width of the error counter.
- ALARM_THRESH, 4: error count at which the alarm asserts; legal range 1..2^CNT_W-1.

REQ-002 The block SHALL have these ports:
- clk, input, 1: rising-edge clock, shared with the full-adder stage.
- rst, input, 1: asynchronous, active-low reset.
- en, input, 1: marks the a/b/cin sample of this cycle as checkable.
- clr, input, 1: synchronous clear of counter, alarm and capture.
- a, input, 1: operand bit, the same net that drives the DUT.
- b, input, 1: operand bit, the same net that drives the DUT.
- cin, input, 1: carry-in, the same net that drives the DUT.
- dut_sum, input, 1: registered sum output of the DUT.
- dut_cout, input, 1: registered carry output of the DUT.
- mismatch, output, 1: registered one-cycle error pulse.
- err_count, output, CNT_W: saturating count of mismatches.
- alarm, output, 1: sticky trojan alarm.
- state, output, 2: FSM state, 0=WARMUP, 1=MONITOR, 2=ALARM.
- cap_valid, output, 1: the capture registers hold a record.
- cap_vec, output, 3: {a,b,cin} of the first mismatching sample.
- cap_stamp, output, 16: cycle stamp of the first mismatch.

Function
REQ-003 a, b, cin and en sampled on edge k SHALL be carried through a LATENCY-deep shift pipeline and compared against dut_sum and dut_cout sampled on edge k+LATENCY.

REQ-004 The golden values SHALL be: expected sum = a^b^cin; expected cout = (a&b)|(a&cin)|(b&cin).

REQ-005 A comparison SHALL be performed only when the delayed en is 1 and state is not WARMUP.

REQ-006 A comparison fails if either bit differs; on failure mismatch SHALL be 1 for exactly the cycle following edge k+LATENCY, and 0 otherwise.

REQ-007 err_count SHALL increment by 1 on each failure and saturate at 2^CNT_W-1 without wrapping.

REQ-008 The FSM SHALL behave as follows:
- WARMUP: lasts exactly LATENCY cycles after reset release, then moves to MONITOR.
- MONITOR: moves to ALARM on the edge where the updated err_count becomes >= ALARM_THRESH.
- ALARM: moves to MONITOR only on clr.

REQ-009 alarm SHALL equal (state==ALARM), driven from a register.

REQ-010 On clr=1, err_count, alarm and cap_valid SHALL clear on that edge.
- clr has priority over a simultaneous failure: that failure is not counted or captured.
- mismatch still pulses for that failure.

REQ-011 A free-running 16-bit cycle counter SHALL start at 0 on reset release and wrap from 16'hFFFF to 0.

REQ-012 clr SHALL NOT affect the delay pipeline, the cycle counter or WARMUP.

Reset
REQ-013 While rst=0, all outputs SHALL be 0, state=WARMUP, the pipeline and the cycle counter SHALL be 0, independent of clk.

REQ-014 Reset asserted mid-operation SHALL discard all in-flight samples; after release the block re-enters WARMUP for LATENCY cycles.

Configuration
REQ-015 With FA_CHECKER_CAPTURE_EN defined, the first failure after reset or clr SHALL load cap_vec and cap_stamp and set cap_valid.
- Later failures SHALL NOT overwrite the capture until the next clr or reset.

REQ-016 Without FA_CHECKER_CAPTURE_EN, cap_valid, cap_vec and cap_stamp SHALL be tied to 0, and the capture registers and the cycle counter SHALL be absent.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Reset release, en=1, golden DUT model, all 8 input vectors repeated 100 times -> mismatch never 1, err_count=0, state=1 from cycle LATENCY onward.
- DUT sum forced inverted for the a=1,b=1,cin=0 sample at cycle 10 -> mismatch=1 at cycle 10+LATENCY, err_count=1, cap_vec=3'b110, cap_stamp=10 (with CAPTURE_EN).
- Four failures with ALARM_THRESH=4 -> alarm rises the cycle after the 4th failure's edge; a fifth failure leaves cap_vec unchanged; clr -> err_count=0, alarm=0, state=1.
- CNT_W=2, ALARM_THRESH=3, cout stuck at 1 for 10 samples -> err_count saturates at 3 and holds.
- clr in the same cycle as a failure -> err_count=0, cap_valid=0, mismatch=1.
- rst pulsed low mid-stream while mismatches are in flight -> all outputs 0 immediately; no mismatch pulse during the following LATENCY cycles.
